// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//  - state_e     : controller states (IDLE, CALC, DONE)
//  - booth_sel_e : partial-product selection produced by the recoder
//  - ext_width() : internal operand width, W+1 rounded up to even
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_e;

  // One spare bit above W lets an unsigned operand be carried as a
  // non-negative two's complement value; rounding to even gives a whole
  // number of two-bit Booth digits.
  function automatic int ext_width(input int w);
    return (w % 2 == 0) ? w + 2 : w + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Modified Booth radix-4 digit recoder.
//  triplet in  3  {b[2i+1], b[2i], b[2i-1]}
//  sel     out    selected partial product: 0, +A, +2A, -A, -2A
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output booth_sel_e sel
);

  // NOTE: every variable written in always_comb gets a value before any
  // branch, so no path can leave it holding its old value (no latch).
  always_comb begin
    sel = ZERO;
    unique case (triplet)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_r4.sv
// Sequential radix-4 (modified Booth) multiplier, two product bits per cycle.
//  clock        in   1    rising-edge clock
//  reset        in   1    asynchronous active-low reset
//  start        in   1    request, accepted only while ready=1
//  signed_mode  in   1    1: operands/product two's complement, 0: unsigned
//  A            in   W    multiplicand, sampled on the accept edge
//  B            in   W    multiplier, sampled on the accept edge
//  P            out  2W   product, held until the next completion
//  ready        out  1    high in IDLE only
//  done         out  1    one-cycle pulse when P is new
// Latency: accept on edge 0, P/done on edge ITER, ready again after ITER+1.
module booth_multiplier_r4
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           ready,
  output logic           done
);

  localparam int EXT   = ext_width(W);
  localparam int ITER  = EXT / 2;
  localparam int CW    = $clog2(ITER);
  localparam int ACC_W = 2 * EXT + 1;
  localparam int PW    = 2 * W;
  localparam logic [EXT:0] ONE = 1;

  state_e           state, state_next;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc, acc_next, summed;
  logic             b_m1;
  logic [EXT-1:0]   mcand;
  logic [EXT-1:0]   a_ext, b_ext;
  logic [EXT:0]     pos1, pos2, pp, upper_sum;
  booth_sel_e       sel;
  logic             accept, last_step;

  assign ready     = (state == IDLE);
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == CALC) && (cnt == CW'(ITER - 1));

  // Sign- or zero-extend according to the mode seen on the accept edge;
  // after that the extended copies carry the mode, so it is not stored.
  assign a_ext = {{(EXT - W){signed_mode & A[W-1]}}, A};
  assign b_ext = {{(EXT - W){signed_mode & B[W-1]}}, B};

  // The multiplier occupies the low EXT bits of the accumulator and is
  // consumed two bits per step as the accumulator shifts right.
  booth_r4_recoder u_recoder (
    .triplet ({acc[1], acc[0], b_m1}),
    .sel     (sel)
  );

  assign pos1 = {mcand[EXT-1], mcand};
  assign pos2 = {mcand, 1'b0};

  always_comb begin
    pp = '0;
    unique case (sel)
      POS1:    pp = pos1;
      POS2:    pp = pos2;
      NEG1:    pp = ~pos1 + ONE;
      NEG2:    pp = ~pos2 + ONE;
      default: pp = '0;
    endcase
  end

  // EXT+1 upper bits are enough: the running partial sum never exceeds
  // twice the multiplicand in magnitude before the shift.
  assign upper_sum = acc[ACC_W-1:EXT] + pp;
  assign summed    = {upper_sum, acc[EXT-1:0]};
  assign acc_next  = $signed(summed) >>> 2;

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves
  // no residue and P reads zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      acc   <= '0;
      b_m1  <= 1'b0;
      mcand <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand <= a_ext;
        acc   <= {{(EXT + 1){1'b0}}, b_ext};
        b_m1  <= 1'b0;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc  <= acc_next;
        b_m1 <= acc[1];
        cnt  <= cnt + 1'b1;
        if (last_step) begin
          P    <= acc_next[PW-1:0];
          done <= 1'b1;
        end
      end
    end
  end

endmodule
